// File: rtl/operand_skew_buffer_pkg.sv
// Shared accelerator constants for the operand skew buffer.
// Tile geometry, counter widths, FSM states and the element slice helper.
package operand_skew_buffer_pkg;

  localparam int SIZE   = 16;
  localparam int DATA_W = 16;
  localparam int LINE_W = 256;
  localparam int IDX_W  = $clog2(SIZE);
  localparam int CNT_W  = $clog2(SIZE + 1);
  localparam int T_W    = $clog2(2 * SIZE - 1);

  typedef enum logic {
    ST_FILL,
    ST_STREAM
  } state_t;

  function automatic logic [DATA_W-1:0] elem(
    input logic [LINE_W-1:0] line,
    input logic [IDX_W-1:0]  e
  );
    return line[e*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/operand_skew_buffer_tile_store.sv
// SIZE x LINE_W register file: one write port, whole array readable.
// Holds one operand tile for the skew buffer.
module tile_store
  import operand_skew_buffer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_we,
  input  logic [IDX_W-1:0]       i_row,
  input  logic [LINE_W-1:0]      i_data,
  output logic [SIZE-1:0][LINE_W-1:0] o_rows
);

  logic [SIZE-1:0][LINE_W-1:0] r_mem;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mem <= '0;
    end else if (i_we) begin
      r_mem[i_row] <= i_data;
    end
  end

  assign o_rows = r_mem;

endmodule

// File: rtl/operand_skew_buffer.sv
// Captures A and B tiles, then replays them diagonally skewed
// onto the systolic array edges.
module operand_skew_buffer
  import operand_skew_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic [LINE_W-1:0] buf_data_in,
  input  logic              read_a,
  input  logic              read_b,
  input  logic              arr_ready,
  output logic              buf_ready,
  output logic [LINE_W-1:0] a_edge,
  output logic [LINE_W-1:0] b_edge,
  output logic              edge_valid,
  output logic              tile_done,
  output logic              proto_err
);

  if (SIZE * DATA_W != LINE_W) begin : g_bad_geometry
    $error("SIZE*DATA_W must equal the line width");
  end

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SIZE);
  localparam logic [T_W-1:0]   T_LAST   = T_W'(2 * SIZE - 2);

  state_t           r_state;
  logic [CNT_W-1:0] r_a_cnt;
  logic [CNT_W-1:0] r_b_cnt;
  logic [T_W-1:0]   r_t;
  logic             r_tile_done;
  logic             r_proto_err;

  logic w_fill;
  logic w_stream;
  logic w_a_full;
  logic w_b_full;
  logic w_we_a;
  logic w_we_b;
  logic w_err;
  int   w_t_i;

  logic [SIZE-1:0][LINE_W-1:0] w_a_rows;
  logic [SIZE-1:0][LINE_W-1:0] w_b_rows;
  logic [LINE_W-1:0]           w_a_edge;
  logic [LINE_W-1:0]           w_b_edge;

  assign w_fill   = (r_state == ST_FILL);
  assign w_stream = (r_state == ST_STREAM);
  assign w_a_full = (r_a_cnt == CNT_FULL);
  assign w_b_full = (r_b_cnt == CNT_FULL);

  // A wins a simultaneous strobe; B is always dropped then
  assign w_we_a = w_fill && read_a && !w_a_full;
  assign w_we_b = w_fill && read_b && !read_a && !w_b_full;

  assign w_err = w_stream ? (read_a || read_b)
               : ((read_a && read_b)
               || (read_a && w_a_full)
               || (read_b && w_b_full));

  tile_store u_a_store (
    .clk    (clk),
    .rstn   (rstn),
    .i_we   (w_we_a),
    .i_row  (r_a_cnt[IDX_W-1:0]),
    .i_data (buf_data_in),
    .o_rows (w_a_rows)
  );

  tile_store u_b_store (
    .clk    (clk),
    .rstn   (rstn),
    .i_we   (w_we_b),
    .i_row  (r_b_cnt[IDX_W-1:0]),
    .i_data (buf_data_in),
    .o_rows (w_b_rows)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_FILL;
      r_a_cnt     <= '0;
      r_b_cnt     <= '0;
      r_t         <= '0;
      r_tile_done <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_tile_done <= 1'b0;
      if (w_err) begin
        r_proto_err <= 1'b1;
      end
      unique case (r_state)
        ST_FILL: begin
          if (w_we_a) begin
            r_a_cnt <= r_a_cnt + 1'b1;
          end
          if (w_we_b) begin
            r_b_cnt <= r_b_cnt + 1'b1;
          end
          if (w_a_full && w_b_full && arr_ready) begin
            r_state <= ST_STREAM;
            r_t     <= '0;
          end
        end
        ST_STREAM: begin
          if (r_t == T_LAST) begin
            r_state     <= ST_FILL;
            r_a_cnt     <= '0;
            r_b_cnt     <= '0;
            r_tile_done <= 1'b1;
          end else begin
            r_t <= r_t + 1'b1;
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  // Skew index is range-checked as a signed int so t-i never wraps
  assign w_t_i = int'(r_t);

  always_comb begin
    w_a_edge = '0;
    w_b_edge = '0;
    if (w_stream) begin
      for (int i = 0; i < SIZE; i++) begin
        if (w_t_i >= i && w_t_i < i + SIZE) begin
          w_a_edge[i*DATA_W +: DATA_W] =
            elem(w_a_rows[i], IDX_W'(w_t_i - i));
          w_b_edge[i*DATA_W +: DATA_W] =
            elem(w_b_rows[IDX_W'(w_t_i - i)], IDX_W'(i));
        end
      end
    end
  end

  assign a_edge     = w_a_edge;
  assign b_edge     = w_b_edge;
  assign edge_valid = w_stream;
  assign buf_ready  = w_fill && !(w_a_full && w_b_full);
  assign tile_done  = r_tile_done;
  assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_operand_skew_buffer.sv
// Self-checking bench for operand_skew_buffer.
// Vector table, directed corner sequences and a randomized model run.
module tb_operand_skew_buffer;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [255:0] buf_data_in = '0;
  logic         read_a = 1'b0;
  logic         read_b = 1'b0;
  logic         arr_ready = 1'b0;
  logic         buf_ready;
  logic [255:0] a_edge;
  logic [255:0] b_edge;
  logic         edge_valid;
  logic         tile_done;
  logic         proto_err;

  int total = 0;
  int bad = 0;

  logic [15:0] MA [16][16];
  logic [15:0] MB [16][16];
  bit m_str, m_err, m_done;
  int m_t, m_na, m_nb;

  typedef struct {
    bit           ra;
    bit           rb;
    bit           ar;
    logic [255:0] d;
    bit           br;
    bit           err;
    bit           ev;
    int           na;
    int           nb;
  } vec_t;

  vec_t tbl [5];

  operand_skew_buffer dut (
    .clk         (clk),
    .rstn        (rstn),
    .buf_data_in (buf_data_in),
    .read_a      (read_a),
    .read_b      (read_b),
    .arr_ready   (arr_ready),
    .buf_ready   (buf_ready),
    .a_edge      (a_edge),
    .b_edge      (b_edge),
    .edge_valid  (edge_valid),
    .tile_done   (tile_done),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [255:0] exp_a();
    logic [255:0] v = '0;
    if (m_str)
      for (int i = 0; i < 16; i++) begin
        int k = m_t - i;
        if (k >= 0 && k < 16) v[i*16 +: 16] = MA[i][k];
      end
    return v;
  endfunction

  function automatic logic [255:0] exp_b();
    logic [255:0] v = '0;
    if (m_str)
      for (int j = 0; j < 16; j++) begin
        int k = m_t - j;
        if (k >= 0 && k < 16) v[j*16 +: 16] = MB[k][j];
      end
    return v;
  endfunction

  task automatic model_step(input bit ra, input bit rb, input bit ar,
                            input logic [255:0] d);
    bit start;
    m_done = 1'b0;
    if (!m_str) begin
      start = (m_na == 16 && m_nb == 16 && ar);
      if (ra) begin
        if (m_na < 16) begin
          for (int e = 0; e < 16; e++) MA[m_na][e] = d[e*16 +: 16];
          m_na++;
        end else m_err = 1'b1;
      end
      if (rb) begin
        if (ra || m_nb == 16) m_err = 1'b1;
        else begin
          for (int e = 0; e < 16; e++) MB[m_nb][e] = d[e*16 +: 16];
          m_nb++;
        end
      end
      if (start) begin
        m_str = 1'b1;
        m_t = 0;
      end
    end else begin
      if (ra || rb) m_err = 1'b1;
      if (m_t == 30) begin
        m_str = 1'b0;
        m_na = 0;
        m_nb = 0;
        m_done = 1'b1;
      end else m_t++;
    end
  endtask

  task automatic check_all();
    bit br;
    br = !m_str && (m_na < 16 || m_nb < 16);
    chk("edge_valid", 256'(edge_valid), 256'(m_str));
    chk("buf_ready", 256'(buf_ready), 256'(br));
    chk("tile_done", 256'(tile_done), 256'(m_done));
    chk("proto_err", 256'(proto_err), 256'(m_err));
    chk("a_edge", a_edge, exp_a());
    chk("b_edge", b_edge, exp_b());
  endtask

  task automatic cyc(input bit ra, input bit rb, input bit ar,
                     input logic [255:0] d);
    read_a = ra;
    read_b = rb;
    arr_ready = ar;
    buf_data_in = d;
    @(posedge clk);
    model_step(ra, rb, ar, d);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    read_a = 1'b0;
    read_b = 1'b0;
    arr_ready = 1'b0;
    buf_data_in = '0;
    m_str = 0; m_t = 0; m_na = 0; m_nb = 0;
    m_err = 0; m_done = 0;
    repeat (3) begin
      @(negedge clk);
      check_all();
      chk("rst_a_cnt", 256'(dut.r_a_cnt), 256'(0));
      chk("rst_b_cnt", 256'(dut.r_b_cnt), 256'(0));
    end
    rstn = 1'b1;
  endtask

  task automatic fill_rand(input int na, input int nb);
    for (int r = 0; r < na; r++) cyc(1, 0, 1, rnd256());
    for (int r = 0; r < nb; r++) cyc(0, 1, 1, rnd256());
  endtask

  task automatic run_to_done();
    int n = 0;
    while (!m_done && n < 80) begin
      cyc(0, 0, 1, '0);
      n++;
    end
    chk("done_seen", 256'(tile_done), 256'(1));
  endtask

  initial begin
    logic [255:0] d;
    int n;
    for (int r = 0; r < 16; r++)
      for (int e = 0; e < 16; e++) begin
        MA[r][e] = '0;
        MB[r][e] = '0;
      end

    tbl[0] = '{1'b1, 1'b1, 1'b1, 256'hABCD, 1'b1, 1'b1, 1'b0, 1, 0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 256'h0011, 1'b1, 1'b1, 1'b0, 1, 1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 256'h0022, 1'b1, 1'b1, 1'b0, 2, 1};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 256'h0033, 1'b1, 1'b1, 1'b0, 2, 1};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 256'h0044, 1'b1, 1'b1, 1'b0, 2, 2};

    do_reset();

    // simultaneous strobes and early fill, table driven
    for (int v = 0; v < 5; v++) begin
      cyc(tbl[v].ra, tbl[v].rb, tbl[v].ar, tbl[v].d);
      chk("tbl_br", 256'(buf_ready), 256'(tbl[v].br));
      chk("tbl_err", 256'(proto_err), 256'(tbl[v].err));
      chk("tbl_ev", 256'(edge_valid), 256'(tbl[v].ev));
      chk("tbl_acnt", 256'(dut.r_a_cnt), 256'(tbl[v].na));
      chk("tbl_bcnt", 256'(dut.r_b_cnt), 256'(tbl[v].nb));
    end
    fill_rand(14, 14);
    cyc(0, 0, 1, '0);
    chk("abcd_a00", 256'(a_edge[15:0]), 256'(16'hABCD));
    run_to_done();

    // identity tile
    do_reset();
    for (int r = 0; r < 16; r++) begin
      d = '0;
      d[r*16 +: 16] = 16'h0001;
      cyc(1, 0, 1, d);
    end
    for (int r = 0; r < 16; r++) cyc(0, 1, 1, {16{16'(r + 1)}});
    cyc(0, 0, 1, '0);
    chk("id_ev0", 256'(edge_valid), 256'(1));
    chk("id_a_row0", 256'(a_edge[15:0]), 256'(1));
    chk("id_b_col0", 256'(b_edge[15:0]), 256'(1));
    for (int c = 1; c <= 30; c++) begin
      cyc(0, 0, 1, '0);
      chk("id_done_early", 256'(tile_done), 256'(0));
    end
    chk("id_a_row15", 256'(a_edge[255:240]), 256'(1));
    chk("id_b_col15", 256'(b_edge[255:240]), 256'(16));
    cyc(0, 0, 1, '0);
    chk("id_done", 256'(tile_done), 256'(1));
    chk("id_done_br", 256'(buf_ready), 256'(1));
    cyc(0, 0, 1, '0);
    chk("id_done_once", 256'(tile_done), 256'(0));

    // interleaved fill, held by arr_ready, then overflow
    do_reset();
    for (int c = 0; c < 32; c++) begin
      if (c % 2 == 0) cyc(1, 0, 0, rnd256());
      else cyc(0, 1, 0, rnd256());
    end
    for (int c = 0; c < 10; c++) begin
      cyc(0, 0, 0, '0);
      chk("hold_ev", 256'(edge_valid), 256'(0));
      chk("hold_err", 256'(proto_err), 256'(0));
    end
    cyc(1, 0, 0, 256'h1234_5678);
    chk("ovf_err", 256'(proto_err), 256'(1));
    chk("ovf_acnt", 256'(dut.r_a_cnt), 256'(16));
    cyc(0, 0, 1, '0);
    chk("start_ev", 256'(edge_valid), 256'(1));
    run_to_done();

    // strobes mid-stream, then back-to-back tile
    do_reset();
    fill_rand(16, 16);
    cyc(0, 0, 1, '0);
    repeat (5) cyc(0, 0, 1, '0);
    chk("t5_err_pre", 256'(proto_err), 256'(0));
    cyc(1, 1, 1, rnd256());
    chk("t5_err", 256'(proto_err), 256'(1));
    run_to_done();
    cyc(1, 0, 1, rnd256());
    chk("b2b_acnt", 256'(dut.r_a_cnt), 256'(1));
    fill_rand(15, 16);
    cyc(0, 0, 1, '0);
    run_to_done();

    // randomized run with a mid-stream reset
    do_reset();
    for (int c = 0; c < 1200; c++) begin
      if (c == 600) begin
        n = 0;
        while (!m_str && n < 200) begin
          cyc(($urandom % 3) == 0, ($urandom % 3) == 0, 1, rnd256());
          n++;
        end
        chk("rnd_reached_stream", 256'(edge_valid), 256'(1));
        repeat (4) cyc(0, 0, 1, '0);
        do_reset();
      end
      cyc(($urandom % 3) == 0, ($urandom % 3) == 0,
          ($urandom % 4) != 0, rnd256());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
